// File: rtl/lc3_pkg.sv
// Shared LC-3 operate-instruction definitions: opcodes, ALU select, controller states,
// condition-code type and the NZP derivation used at writeback.
package lc3_pkg;

  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_NOT   = 4'b1001;
  localparam logic [5:0] NOT_TAIL = 6'h3F;

  typedef enum logic [1:0] {
    ALU_ADD  = 2'b00,
    ALU_AND  = 2'b01,
    ALU_NOT  = 2'b10,
    ALU_PASS = 2'b11
  } alu_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DECODE,
    S_EXECUTE,
    S_WRITEBACK
  } ctrl_state_t;

  typedef struct packed {
    logic n;
    logic z;
    logic p;
  } nzp_t;

  localparam nzp_t NZP_RESET = '{n: 1'b0, z: 1'b1, p: 1'b0};

  // Exactly one flag is set; a negative value never reports zero.
  function automatic nzp_t calc_nzp(input logic sign, input logic zero);
    nzp_t r;
    r.n = sign;
    r.z = !sign && zero;
    r.p = !sign && !zero;
    return r;
  endfunction

endpackage

// File: rtl/lc3_sext.sv
// Sign extender for LC-3 immediate/offset fields: replicates the field's MSB up to OUT_W.
module lc3_sext #(
  parameter int IN_W  = 5,
  parameter int OUT_W = 16
) (
  input  logic [IN_W-1:0]  i_in,
  output logic [OUT_W-1:0] o_out
);

  assign o_out = {{(OUT_W-IN_W){i_in[IN_W-1]}}, i_in};

endmodule

// File: rtl/alu_op_controller.sv
// Multi-cycle issue controller for LC-3 ADD/AND/NOT: decodes one instruction per handshake,
// steers the ALU, writes the result back and updates the condition codes.
//   state       | meaning
//   S_IDLE      | ready for a new instruction, ALU held at PASS
//   S_DECODE    | check opcode legality, register source addresses
//   S_EXECUTE   | drive ALU op and operand B, capture ALU result
//   S_WRITEBACK | one-cycle regfile write, done pulse, NZP update
module alu_op_controller
  import lc3_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int IMM_W  = 5
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [15:0]       instr,
  output logic [2:0]        SR1,
  output logic [2:0]        SR2,
  input  logic [DATA_W-1:0] SR1OUT,
  input  logic [DATA_W-1:0] SR2OUT,
  output logic [1:0]        ALU_signal,
  output logic [DATA_W-1:0] SR2MUXOUT,
  input  logic [DATA_W-1:0] ALU_OUT,
  output logic              LD_REG,
  output logic [2:0]        DR,
  output logic [DATA_W-1:0] REG_WDATA,
  output logic [2:0]        NZP,
  output logic              done,
  output logic              illegal
);

  ctrl_state_t       r_state;
  ctrl_state_t       w_state_nxt;
  logic [15:0]       r_instr;
  logic [2:0]        r_sr1;
  logic [2:0]        r_sr2;
  logic [DATA_W-1:0] r_result;
  nzp_t              r_nzp;

  logic [3:0]        w_opcode;
  logic              w_legal;
  alu_op_t           w_alu_op;
  logic [DATA_W-1:0] w_imm_sext;
  logic              w_unused_sr1;

  // SR1OUT feeds the ALU directly; the controller only names it for the regfile interface.
  assign w_unused_sr1 = ^SR1OUT;

  assign w_opcode = r_instr[15:12];
  assign w_legal  = (w_opcode == OP_ADD) || (w_opcode == OP_AND) ||
                    ((w_opcode == OP_NOT) && (r_instr[5:0] == NOT_TAIL));

  always_comb begin
    w_alu_op = ALU_PASS;
    case (w_opcode)
      OP_ADD:  w_alu_op = ALU_ADD;
      OP_AND:  w_alu_op = ALU_AND;
      OP_NOT:  w_alu_op = ALU_NOT;
      default: w_alu_op = ALU_PASS;
    endcase
  end

  lc3_sext #(.IN_W(IMM_W), .OUT_W(DATA_W)) u_imm_sext (
    .i_in  (r_instr[IMM_W-1:0]),
    .o_out (w_imm_sext)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    instr_ready = 1'b0;
    ALU_signal  = ALU_PASS;
    SR2MUXOUT   = '0;
    LD_REG      = 1'b0;
    DR          = '0;
    REG_WDATA   = '0;
    done        = 1'b0;
    illegal     = 1'b0;
    case (r_state)
      S_IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) w_state_nxt = S_DECODE;
      end
      S_DECODE: begin
        illegal     = !w_legal;
        w_state_nxt = w_legal ? S_EXECUTE : S_IDLE;
      end
      S_EXECUTE: begin
        ALU_signal  = w_alu_op;
        SR2MUXOUT   = r_instr[5] ? w_imm_sext : SR2OUT;
        w_state_nxt = S_WRITEBACK;
      end
      S_WRITEBACK: begin
        LD_REG      = 1'b1;
        DR          = r_instr[11:9];
        REG_WDATA   = r_result;
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_instr  <= '0;
      r_sr1    <= '0;
      r_sr2    <= '0;
      r_result <= '0;
      r_nzp    <= NZP_RESET;
    end else begin
      if (r_state == S_IDLE && instr_valid) r_instr <= instr;
      if (r_state == S_DECODE && w_legal) begin
        r_sr1 <= r_instr[8:6];
        r_sr2 <= r_instr[2:0];
      end
      if (r_state == S_EXECUTE)   r_result <= ALU_OUT;
      if (r_state == S_WRITEBACK) r_nzp    <= calc_nzp(r_result[DATA_W-1], r_result == '0);
    end
  end

  assign SR1 = r_sr1;
  assign SR2 = r_sr2;
  assign NZP = r_nzp;

endmodule

// File: tb/tb_alu_op_controller.sv
// Bench for alu_op_controller: behavioural regfile/ALU environment plus an instruction-level
// reference model that predicts each writeback, illegal pulse, ready window and NZP.
module tb_alu_op_controller;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = 16'h0000;
  logic        instr_ready;
  logic [2:0]  SR1, SR2, DR, NZP;
  logic [15:0] SR1OUT, SR2OUT, SR2MUXOUT, ALU_OUT, REG_WDATA;
  logic [1:0]  ALU_signal;
  logic        LD_REG, done, illegal;

  logic        pre_we = 1'b0;
  logic [2:0]  pre_a = 3'd0;
  logic [15:0] pre_d = 16'h0000;

  logic [15:0] rf     [8];
  logic [15:0] rf_ref [8];
  logic [2:0]  ref_nzp = 3'b010;
  int          cyc = 0;
  int          busy_until = 0;
  int          n_checks = 0;
  int          n_fail = 0;

  typedef struct {
    int          cyc;
    bit          legal;
    logic [15:0] w;
    logic [15:0] b;
    logic [15:0] res;
    logic [1:0]  op;
  } exp_t;
  exp_t q[$];

  always #5 Clk = ~Clk;

  alu_op_controller #(.DATA_W(16), .IMM_W(5)) dut (
    .Clk(Clk), .Reset(Reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .SR1(SR1), .SR2(SR2), .SR1OUT(SR1OUT), .SR2OUT(SR2OUT),
    .ALU_signal(ALU_signal), .SR2MUXOUT(SR2MUXOUT), .ALU_OUT(ALU_OUT), .LD_REG(LD_REG),
    .DR(DR), .REG_WDATA(REG_WDATA), .NZP(NZP), .done(done), .illegal(illegal)
  );

  assign SR1OUT = rf[SR1];
  assign SR2OUT = rf[SR2];

  always_comb begin
    ALU_OUT = SR1OUT;
    case (ALU_signal)
      2'b00:   ALU_OUT = SR1OUT + SR2MUXOUT;
      2'b01:   ALU_OUT = SR1OUT & SR2MUXOUT;
      2'b10:   ALU_OUT = ~SR1OUT;
      default: ALU_OUT = SR1OUT;
    endcase
  end

  always @(posedge Clk) begin
    cyc <= cyc + 1;
    if (pre_we)      rf[pre_a] <= pre_d;
    else if (LD_REG) rf[DR]    <= REG_WDATA;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [15:0] sext5(input logic [4:0] v);
    int x;
    x = int'(v);
    if (x > 15) x = x - 32;
    return 16'(x);
  endfunction

  function automatic logic [2:0] nzp_of(input logic [15:0] v);
    if (v == 16'h0000) return 3'b010;
    if (v >= 16'h8000) return 3'b100;
    return 3'b001;
  endfunction

  // Instruction-level reference: outcome predicted from the architectural regfile at handshake.
  function automatic exp_t predict(input logic [15:0] w, input int hs_cyc);
    exp_t e;
    logic [15:0] a;
    e.cyc = hs_cyc;
    e.w   = w;
    a     = rf_ref[w[8:6]];
    e.b   = w[5] ? sext5(w[4:0]) : rf_ref[w[2:0]];
    e.legal = 1'b0;
    e.op  = 2'b11;
    e.res = 16'h0000;
    if (w[15:12] == 4'b0001) begin
      e.legal = 1'b1; e.op = 2'b00;
      e.res = 16'((int'(a) + int'(e.b)) % 65536);
    end else if (w[15:12] == 4'b0101) begin
      e.legal = 1'b1; e.op = 2'b01;
      e.res = a & e.b;
    end else if (w[15:12] == 4'b1001 && w[5:0] == 6'h3F) begin
      e.legal = 1'b1; e.op = 2'b10;
      e.res = 16'(65535 - int'(a));
    end
    return e;
  endfunction

  always @(negedge Clk) begin
    exp_t e;
    bit   exp_ready, exp_ld, exp_ill;
    if (pre_we) rf_ref[pre_a] = pre_d;
    if (Reset) begin
      q.delete();
      busy_until = 0;
      ref_nzp = 3'b010;
      chk("rst_ready", instr_ready, 1'b1);
      chk("rst_ld_reg", LD_REG, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_illegal", illegal, 1'b0);
      chk("rst_nzp", NZP, 3'b010);
      chk("rst_alu_signal", ALU_signal, 2'b11);
      chk("rst_sr1", SR1, 3'd0);
      chk("rst_sr2", SR2, 3'd0);
      chk("rst_dr", DR, 3'd0);
      chk("rst_sr2mux", SR2MUXOUT, 16'h0000);
      chk("rst_wdata", REG_WDATA, 16'h0000);
    end else begin
      exp_ready = (cyc >= busy_until);
      chk("instr_ready", instr_ready, exp_ready);
      chk("nzp", NZP, ref_nzp);
      exp_ld  = 1'b0;
      exp_ill = 1'b0;
      if (q.size() > 0) begin
        e = q[0];
        if (!e.legal && cyc == e.cyc + 1) exp_ill = 1'b1;
        if (e.legal && cyc == e.cyc + 2) begin
          chk("exec_alu_signal", ALU_signal, e.op);
          chk("exec_sr1", SR1, e.w[8:6]);
          chk("exec_sr2", SR2, e.w[2:0]);
          chk("exec_sr2mux", SR2MUXOUT, e.b);
        end
        if (e.legal && cyc == e.cyc + 3) exp_ld = 1'b1;
      end
      chk("ld_reg", LD_REG, exp_ld);
      chk("done", done, exp_ld);
      chk("illegal", illegal, exp_ill);
      if (exp_ld) begin
        chk("wb_dr", DR, e.w[11:9]);
        chk("wb_wdata", REG_WDATA, e.res);
        rf_ref[e.w[11:9]] = e.res;
        ref_nzp = nzp_of(e.res);
        void'(q.pop_front());
      end
      if (exp_ill) void'(q.pop_front());
      if (exp_ready && instr_valid) begin
        e = predict(instr, cyc);
        q.push_back(e);
        busy_until = cyc + (e.legal ? 4 : 2);
      end
    end
  end

  task automatic set_reg(input logic [2:0] r, input logic [15:0] v);
    @(posedge Clk); #1;
    pre_we = 1'b1; pre_a = r; pre_d = v;
    @(posedge Clk); #1;
    pre_we = 1'b0;
  endtask

  task automatic issue(input logic [15:0] w);
    bit got;
    @(posedge Clk); #1;
    instr = w;
    instr_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge Clk);
      if (instr_ready) got = 1'b1;
    end
    if (!got) chk("handshake_timeout", instr_ready, 1'b1);
    @(posedge Clk); #1;
    instr_valid = 1'b0;
    instr = 16'($urandom);
  endtask

  task automatic wait_idle();
    repeat (6) @(posedge Clk);
    #1;
  endtask

  function automatic logic [15:0] rand_instr();
    logic [15:0] w;
    int sel;
    w = 16'($urandom);
    sel = int'($urandom_range(0, 9));
    if (sel <= 3)      w[15:12] = 4'b0001;
    else if (sel <= 6) w[15:12] = 4'b0101;
    else if (sel <= 8) begin
      w[15:12] = 4'b1001;
      if ($urandom_range(0, 3) != 0) w[5:0] = 6'h3F;
    end
    return w;
  endfunction

  initial begin
    logic [15:0] r7_before;
    repeat (3) @(posedge Clk);
    #1 Reset = 1'b0;
    for (int r = 0; r < 8; r++) set_reg(3'(r), 16'($urandom));

    set_reg(3'd2, 16'd5);
    set_reg(3'd3, 16'd7);
    issue(16'h1283);               // ADD R1,R2,R3
    wait_idle();
    chk("add_r1_value", rf[1], 16'd12);
    chk("add_nzp", NZP, 3'b001);

    set_reg(3'd4, 16'h00F0);
    issue(16'h5130);               // AND R0,R4,#-16
    wait_idle();
    chk("and_r0_value", rf[0], 16'h00F0);
    chk("and_nzp", NZP, 3'b001);

    set_reg(3'd5, 16'hFFFF);
    issue(16'h9B7F);               // NOT R5,R5
    wait_idle();
    chk("not_r5_value", rf[5], 16'h0000);
    chk("not_nzp", NZP, 3'b010);

    set_reg(3'd6, 16'h0000);
    issue(16'h1DBF);               // ADD R6,R6,#-1
    wait_idle();
    chk("add_imm_r6_value", rf[6], 16'hFFFF);
    chk("add_imm_nzp", NZP, 3'b100);

    issue(16'h0000);               // reserved opcode
    issue(16'h9B40);               // NOT with bad tail
    wait_idle();
    chk("illegal_nzp_kept", NZP, 3'b100);

    r7_before = rf[7];
    issue(16'h1E61);               // ADD R7,R1,#1, killed by reset in EXECUTE
    @(posedge Clk); #1;
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset = 1'b0;
    wait_idle();
    chk("reset_drop_r7", rf[7], r7_before);
    chk("reset_nzp", NZP, 3'b010);
    issue(16'h1E61);
    wait_idle();

    for (int i = 0; i < 40; i++) issue(rand_instr());
    wait_idle();

    @(posedge Clk); #1;
    instr_valid = 1'b1;
    for (int i = 0; i < 48; i++) begin
      instr = rand_instr();
      @(posedge Clk); #1;
    end
    instr_valid = 1'b0;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
